// File: rtl/nn_pkg.sv
// nn_pkg: shared defaults, FSM state type and saturation constant for the neuron datapath.
package nn_pkg;
    localparam int NN_DATA_W = 8;
    localparam int NN_ACC_W = 24;
    localparam int NN_FRAC = 4;
    localparam int NN_ADDR_W = 8;
    localparam logic [7:0] SAT_MAX = 8'h7F;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/nn_activation.sv
// nn_activation: ReLU plus requantize of an accumulator sum back to a saturated Q4.4 word.
module nn_activation
    import nn_pkg::*;
#(
    parameter int ACC_W = NN_ACC_W,
    parameter int DATA_W = NN_DATA_W,
    parameter int FRAC = NN_FRAC
) (
    input  logic signed [ACC_W-1:0] sum,
    output logic        [DATA_W-1:0] act
);
    logic signed [ACC_W-1:0] sh;
    always_comb begin
        sh = sum >>> FRAC;
        act = sum[ACC_W-1] ? '0 : (|sh[ACC_W-1:DATA_W-1]) ? DATA_W'(SAT_MAX) : sh[DATA_W-1:0];
    end
endmodule

// File: rtl/neuron_accumulator.sv
// neuron_accumulator: three-stage multiply-accumulate over address-generator beats,
// writing one activated result per neuron.
module neuron_accumulator
    import nn_pkg::*;
#(
    parameter int DATA_W = NN_DATA_W,
    parameter int ACC_W = NN_ACC_W,
    parameter int FRAC = NN_FRAC,
    parameter int ADDR_W = NN_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              beat_valid,
    input  logic              neuron_last,
    input  logic              layer_last,
    input  logic [ADDR_W-1:0] wr_addr_in,
    input  logic [DATA_W-1:0] weight_data,
    input  logic [DATA_W-1:0] neuro_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              layer_done
);
    state_t state_q, state_d;
    logic s1_v_q, s1_v_d, s1_nl_q, s1_nl_d, s1_ll_q, s1_ll_d;
    logic s2_v_q, s2_v_d, s2_nl_q, s2_nl_d, s2_ll_q, s2_ll_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d, s2_addr_q, s2_addr_d, wr_addr_q, wr_addr_d;
    logic signed [2*DATA_W-1:0] s2_prod_q, s2_prod_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, sum;
    logic [DATA_W-1:0] wr_data_q, wr_data_d, act;
    logic wr_en_q, wr_en_d, busy_q, busy_d, layer_done_q, layer_done_d;
    logic accept, fire;

    nn_activation #(.ACC_W(ACC_W), .DATA_W(DATA_W), .FRAC(FRAC)) u_act (.sum(sum), .act(act));

    always_comb begin
        accept = state_q == RUN && beat_valid && !start;
        fire = s2_v_q && s2_nl_q && !start;
        sum = acc_q + {{(ACC_W-2*DATA_W){s2_prod_q[2*DATA_W-1]}}, s2_prod_q};
        state_d = start ? RUN
                : (accept && layer_last) ? DRAIN
                : (state_q == DRAIN && layer_done_q) ? IDLE : state_q;
        s1_v_d = accept;
        s1_nl_d = accept && neuron_last;
        s1_ll_d = accept && layer_last;
        s1_addr_d = wr_addr_in;
        // RAM data lands one cycle after its beat, so the product is formed against stage-1 flags
        s2_v_d = s1_v_q && !start;
        s2_nl_d = s1_nl_q && !start;
        s2_ll_d = s1_ll_q && !start;
        s2_addr_d = s1_addr_q;
        s2_prod_d = $signed(weight_data) * $signed(neuro_data);
        acc_d = (start || (s2_v_q && s2_nl_q)) ? '0 : s2_v_q ? sum : acc_q;
        wr_en_d = fire;
        layer_done_d = fire && s2_ll_q;
        wr_addr_d = fire ? s2_addr_q : wr_addr_q;
        wr_data_d = fire ? act : wr_data_q;
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            s1_v_q <= 1'b0;
            s1_nl_q <= 1'b0;
            s1_ll_q <= 1'b0;
            s1_addr_q <= '0;
            s2_v_q <= 1'b0;
            s2_nl_q <= 1'b0;
            s2_ll_q <= 1'b0;
            s2_addr_q <= '0;
            s2_prod_q <= '0;
            acc_q <= '0;
            wr_en_q <= 1'b0;
            layer_done_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_v_q <= s1_v_d;
            s1_nl_q <= s1_nl_d;
            s1_ll_q <= s1_ll_d;
            s1_addr_q <= s1_addr_d;
            s2_v_q <= s2_v_d;
            s2_nl_q <= s2_nl_d;
            s2_ll_q <= s2_ll_d;
            s2_addr_q <= s2_addr_d;
            s2_prod_q <= s2_prod_d;
            acc_q <= acc_d;
            wr_en_q <= wr_en_d;
            layer_done_q <= layer_done_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q <= busy_d;
        end
    end

    assign wr_en = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy = busy_q;
    assign layer_done = layer_done_q;
endmodule

// File: tb/tb_neuron_accumulator.sv
// tb_neuron_accumulator: directed vectors with hand-computed results for neuron_accumulator.
module tb_neuron_accumulator;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic beat_valid = 1'b0, neuron_last = 1'b0, layer_last = 1'b0;
    logic [7:0] wr_addr_in = '0, weight_data = '0, neuro_data = '0, w_in = '0, x_in = '0;
    logic wr_en, busy, layer_done, seen;
    logic [7:0] wr_addr, wr_data;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    // weight/neuron RAM model: read data appears one cycle after the beat
    always @(posedge clk) begin
        weight_data <= w_in;
        neuro_data <= x_in;
    end

    neuron_accumulator dut (
        .clk(clk), .reset(reset), .start(start), .beat_valid(beat_valid),
        .neuron_last(neuron_last), .layer_last(layer_last), .wr_addr_in(wr_addr_in),
        .weight_data(weight_data), .neuro_data(neuro_data), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .layer_done(layer_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v, input logic nl, input logic ll,
                        input logic [7:0] a, input logic [7:0] w, input logic [7:0] x);
        beat_valid = v;
        neuron_last = nl;
        layer_last = ll;
        wr_addr_in = a;
        w_in = w;
        x_in = x;
        tick();
    endtask

    task automatic idle();
        beat(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        idle();
        start = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic [7:0] a, input logic [7:0] d, input logic ld);
        chk({tag, "_en"}, {7'd0, wr_en}, 8'd1);
        chk({tag, "_addr"}, wr_addr, a);
        chk({tag, "_data"}, wr_data, d);
        chk({tag, "_done"}, {7'd0, layer_done}, {7'd0, ld});
    endtask

    initial begin
        tick();
        tick();
        chk("rst_wr_en", {7'd0, wr_en}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, layer_done}, 8'd0);
        chk("rst_addr", wr_addr, 8'h00);
        chk("rst_data", wr_data, 8'h00);
        reset = 1'b0;
        beat(1'b1, 1'b1, 1'b0, 8'h01, 8'h10, 8'h10);
        chk("idle_ignored_busy", {7'd0, busy}, 8'd0);
        idle();
        idle();
        chk("idle_ignored_wr", {7'd0, wr_en}, 8'd0);

        pulse_start();
        chk("start_busy", {7'd0, busy}, 8'd1);
        beat(1'b1, 1'b0, 1'b0, 8'h05, 8'h10, 8'h10);
        beat(1'b1, 1'b0, 1'b0, 8'h05, 8'h10, 8'h20);
        beat(1'b1, 1'b1, 1'b0, 8'h05, 8'h10, 8'h30);
        chk("n3_early1", {7'd0, wr_en}, 8'd0);
        beat(1'b1, 1'b1, 1'b0, 8'h06, 8'hF0, 8'h20);
        chk("n3_early2", {7'd0, wr_en}, 8'd0);
        idle();
        chk_wr("n3", 8'h05, 8'h60, 1'b0);
        beat(1'b1, 1'b0, 1'b0, 8'h07, 8'h7F, 8'h7F);
        chk_wr("relu", 8'h06, 8'h00, 1'b0);
        beat(1'b1, 1'b0, 1'b0, 8'h07, 8'h7F, 8'h7F);
        chk("bubble_no_wr", {7'd0, wr_en}, 8'd0);
        beat(1'b1, 1'b0, 1'b0, 8'h07, 8'h7F, 8'h7F);
        beat(1'b1, 1'b1, 1'b1, 8'h07, 8'h7F, 8'h7F);
        chk("drain_busy", {7'd0, busy}, 8'd1);
        beat(1'b1, 1'b1, 1'b0, 8'h09, 8'h10, 8'h10);
        idle();
        chk_wr("sat", 8'h07, 8'h7F, 1'b1);
        chk("sat_busy", {7'd0, busy}, 8'd1);
        idle();
        chk("end_busy", {7'd0, busy}, 8'd0);
        chk("drain_beat_ignored", {7'd0, wr_en}, 8'd0);
        chk("end_done", {7'd0, layer_done}, 8'd0);

        pulse_start();
        beat(1'b1, 1'b1, 1'b0, 8'h08, 8'h10, 8'h10);
        beat(1'b1, 1'b1, 1'b1, 8'h09, 8'h20, 8'h10);
        idle();
        chk_wr("b2b_a", 8'h08, 8'h10, 1'b0);
        idle();
        chk_wr("b2b_b", 8'h09, 8'h20, 1'b1);
        chk("b2b_busy_hi", {7'd0, busy}, 8'd1);
        idle();
        chk("b2b_busy_lo", {7'd0, busy}, 8'd0);
        chk("b2b_wr_lo", {7'd0, wr_en}, 8'd0);

        pulse_start();
        beat(1'b1, 1'b0, 1'b0, 8'h05, 8'h10, 8'h10);
        beat(1'b1, 1'b0, 1'b0, 8'h05, 8'h10, 8'h20);
        reset = 1'b1;
        start = 1'b1;
        beat(1'b1, 1'b1, 1'b1, 8'h05, 8'h10, 8'h30);
        reset = 1'b0;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen |= wr_en;
            idle();
        end
        chk("mid_rst_no_wr", {7'd0, seen}, 8'd0);
        chk("mid_rst_busy", {7'd0, busy}, 8'd0);
        pulse_start();
        beat(1'b1, 1'b0, 1'b0, 8'h05, 8'h10, 8'h10);
        beat(1'b1, 1'b0, 1'b0, 8'h05, 8'h10, 8'h20);
        beat(1'b1, 1'b1, 1'b1, 8'h05, 8'h10, 8'h30);
        idle();
        idle();
        chk_wr("after_rst", 8'h05, 8'h60, 1'b1);
        idle();

        pulse_start();
        beat(1'b1, 1'b0, 1'b0, 8'h03, 8'h7F, 8'h7F);
        beat(1'b1, 1'b0, 1'b0, 8'h03, 8'h7F, 8'h7F);
        pulse_start();
        chk("restart_busy", {7'd0, busy}, 8'd1);
        beat(1'b1, 1'b1, 1'b1, 8'h04, 8'h10, 8'h20);
        chk("restart_no_wr", {7'd0, wr_en}, 8'd0);
        idle();
        idle();
        chk_wr("restart", 8'h04, 8'h20, 1'b1);
        idle();
        idle();
        chk("final_busy", {7'd0, busy}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
